// File: rtl/mp5_pkg.sv
// Shared MP5 types: stage geometry, packet formats and phantom-map entry/FSM types.
package mp5_pkg;

    localparam int NUM_PIPELINES = 2;
    localparam int NUM_STAGES    = 4;
    localparam int FIFO_SIZE     = 8;
    localparam int ID_W          = 16;

    localparam int FIFO_ID_W = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1;
    localparam int ADDR_W    = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;

    // Packet travelling through a stage; phantom packets only reserve a slot.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            phantom;
        logic [7:0]      data;
    } Packet;

    // One slot of a stage FIFO.
    typedef struct packed {
        logic  valid;
        Packet pkt;
    } FIFO_Entry;

    // Location of a slot inside a stage.
    typedef struct packed {
        logic [FIFO_ID_W-1:0] fifo_id;
        logic [ADDR_W-1:0]    addr;
    } Entry;

    // Phantom reservation: packet id -> FIFO and slot.
    typedef struct packed {
        logic                 valid;
        logic [ID_W-1:0]      id;
        logic [FIFO_ID_W-1:0] fifo_id;
        logic [ADDR_W-1:0]    addr;
    } Map_Entry;

    // Lookup engine states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        INSERT = 2'd2
    } map_state_e;

endpackage

// File: rtl/mp5_map_match.sv
// Combinational priority match of a key against the valid map entries.
module mp5_map_match
    import mp5_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [DEPTH-1:0] i_valid,
    input  logic [ID_W-1:0]  i_ids [DEPTH],
    input  logic [ID_W-1:0]  i_key,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so that the lowest matching index wins.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_ids[i] == i_key)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mp5_phantom_map.sv
// Phantom-reservation map: records reserved slots on push and fills them when
// the real packet arrives, then frees the reservation.
module mp5_phantom_map #(
    parameter int NUM_PIPELINES = 2,
    parameter int FIFO_SIZE     = 8,
    parameter int MAP_DEPTH     = 8,
    localparam int FID_W = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1,
    localparam int AD_W  = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1,
    localparam int CNT_W = $clog2(MAP_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rec_valid,
    input  logic [15:0]          rec_id,
    input  logic [FID_W-1:0]     rec_fifo_id,
    input  logic [AD_W-1:0]      rec_addr,
    output logic                 rec_ready,
    output logic                 rec_drop,
    input  logic                 pkt_valid,
    input  mp5_pkg::Packet       pkt_in,
    output logic                 pkt_ready,
    output logic                 ins_valid,
    output logic [FID_W-1:0]     ins_fifo_id,
    output logic [AD_W-1:0]      ins_addr,
    output mp5_pkg::Packet       ins_pkt,
    input  logic                 ins_ack,
    output logic                 miss,
    output logic [CNT_W-1:0]     map_count
);

    import mp5_pkg::*;

    localparam int               IDX_W   = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MAP_DEPTH);

    // Reservation table
    logic [MAP_DEPTH-1:0] r_valid;
    logic [ID_W-1:0]      r_id   [MAP_DEPTH];
    logic [FID_W-1:0]     r_fifo [MAP_DEPTH];
    logic [AD_W-1:0]      r_addr [MAP_DEPTH];
    logic [CNT_W-1:0]     r_count;
    logic                 r_rec_drop;

    // Lookup engine
    map_state_e           r_state;
    Packet                r_pkt;
    logic [FID_W-1:0]     r_ins_fifo;
    logic [AD_W-1:0]      r_ins_addr;
    logic [IDX_W-1:0]     r_hit_idx;
    logic                 r_miss;

    logic                 w_rec_hit;
    logic [IDX_W-1:0]     w_rec_idx;
    logic                 w_lk_hit;
    logic [IDX_W-1:0]     w_lk_idx;
    logic                 w_has_free;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_alloc;
    logic                 w_free;
    logic                 w_not_full;

    // Duplicate-id check for incoming reservation reports.
    mp5_map_match #(.DEPTH(MAP_DEPTH), .IDX_W(IDX_W)) u_rec_match (
        .i_valid (r_valid),
        .i_ids   (r_id),
        .i_key   (rec_id),
        .o_hit   (w_rec_hit),
        .o_idx   (w_rec_idx)
    );

    // Reservation lookup for the latched real packet.
    mp5_map_match #(.DEPTH(MAP_DEPTH), .IDX_W(IDX_W)) u_lk_match (
        .i_valid (r_valid),
        .i_ids   (r_id),
        .i_key   (r_pkt.id),
        .o_hit   (w_lk_hit),
        .o_idx   (w_lk_idx)
    );

    // Lowest-index free entry; an entry being freed this cycle is still valid here.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = MAP_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_not_full = (r_count < DEPTH_C);
    assign w_alloc    = rec_valid && !w_rec_hit && w_not_full && w_has_free;
    assign w_free     = (r_state == INSERT) && ins_ack;

    // Entry valid bits: allocate on new reports, clear on the insert ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (w_free) begin
                r_valid[r_hit_idx] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[w_free_idx] <= 1'b1;
            end
        end
    end

    // Entry payload: overwrite on duplicate id, fill on allocation.
    always_ff @(posedge clk) begin
        if (rec_valid && w_rec_hit) begin
            r_fifo[w_rec_idx] <= rec_fifo_id;
            r_addr[w_rec_idx] <= rec_addr;
        end else if (w_alloc) begin
            r_id[w_free_idx]   <= rec_id;
            r_fifo[w_free_idx] <= rec_fifo_id;
            r_addr[w_free_idx] <= rec_addr;
        end
    end

    // Occupancy count and drop pulse for reports that found the map full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_rec_drop <= 1'b0;
        end else begin
            r_count    <= r_count + CNT_W'(w_alloc) - CNT_W'(w_free);
            r_rec_drop <= rec_valid && !w_rec_hit && !w_not_full;
        end
    end

    // Lookup FSM: latch packet, match once, then hold the insert until acked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pkt      <= '0;
            r_ins_fifo <= '0;
            r_ins_addr <= '0;
            r_hit_idx  <= '0;
            r_miss     <= 1'b0;
        end else begin
            r_miss <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pkt_valid) begin
                        r_pkt   <= pkt_in;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_lk_hit) begin
                        r_ins_fifo <= r_fifo[w_lk_idx];
                        r_ins_addr <= r_addr[w_lk_idx];
                        r_hit_idx  <= w_lk_idx;
                        r_state    <= INSERT;
                    end else begin
                        r_miss  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                INSERT: begin
                    if (ins_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rec_ready   = w_not_full;
    assign rec_drop    = r_rec_drop;
    assign pkt_ready   = (r_state == IDLE);
    assign ins_valid   = (r_state == INSERT);
    assign ins_fifo_id = r_ins_fifo;
    assign ins_addr    = r_ins_addr;
    assign ins_pkt     = r_pkt;
    assign miss        = r_miss;
    assign map_count   = r_count;

endmodule

// File: tb/tb_mp5_phantom_map.sv
// Directed bench for the phantom-reservation map.
module tb_mp5_phantom_map;

    import mp5_pkg::*;

    logic           clk;
    logic           rst;
    logic           rec_valid;
    logic [15:0]    rec_id;
    logic [0:0]     rec_fifo_id;
    logic [2:0]     rec_addr;
    logic           rec_ready;
    logic           rec_drop;
    logic           pkt_valid;
    Packet          pkt_in;
    logic           pkt_ready;
    logic           ins_valid;
    logic [0:0]     ins_fifo_id;
    logic [2:0]     ins_addr;
    Packet          ins_pkt;
    logic           ins_ack;
    logic           miss;
    logic [3:0]     map_count;

    int n_total;
    int n_bad;

    mp5_phantom_map #(.NUM_PIPELINES(2), .FIFO_SIZE(8), .MAP_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rec_valid   (rec_valid),
        .rec_id      (rec_id),
        .rec_fifo_id (rec_fifo_id),
        .rec_addr    (rec_addr),
        .rec_ready   (rec_ready),
        .rec_drop    (rec_drop),
        .pkt_valid   (pkt_valid),
        .pkt_in      (pkt_in),
        .pkt_ready   (pkt_ready),
        .ins_valid   (ins_valid),
        .ins_fifo_id (ins_fifo_id),
        .ins_addr    (ins_addr),
        .ins_pkt     (ins_pkt),
        .ins_ack     (ins_ack),
        .miss        (miss),
        .map_count   (map_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input logic [15:0] id, input logic [0:0] fid, input logic [2:0] addr);
        rec_valid   = 1'b1;
        rec_id      = id;
        rec_fifo_id = fid;
        rec_addr    = addr;
        tick();
        rec_valid   = 1'b0;
    endtask

    // Presents a packet and steps through the LOOKUP cycle.
    task automatic lookup(input logic [15:0] id, input logic [7:0] data);
        pkt_valid      = 1'b1;
        pkt_in.id      = id;
        pkt_in.phantom = 1'b0;
        pkt_in.data    = data;
        tick();
        pkt_valid = 1'b0;
        chk("accept_busy", {31'd0, pkt_ready}, 32'd0);
        tick();
    endtask

    initial begin
        Packet exp_pkt;
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b0;
        rec_valid = 1'b0;
        rec_id    = '0;
        rec_fifo_id = '0;
        rec_addr  = '0;
        pkt_valid = 1'b0;
        pkt_in    = '0;
        ins_ack   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_miss", {31'd0, miss}, 32'd0);
        chk("rst_drop", {31'd0, rec_drop}, 32'd0);
        chk("rst_count", {28'd0, map_count}, 32'd0);
        chk("rst_ins_fifo", {31'd0, ins_fifo_id}, 32'd0);
        chk("rst_ins_addr", {29'd0, ins_addr}, 32'd0);
        chk("rst_ins_pkt", 32'(ins_pkt), 32'd0);
        chk("rst_rec_ready", {31'd0, rec_ready}, 32'd1);
        chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        rst = 1'b1;
        tick();

        // Basic record then fill
        record(16'h0005, 1'b1, 3'd3);
        chk("t1_count1", {28'd0, map_count}, 32'd1);
        lookup(16'h0005, 8'hA5);
        exp_pkt = '{id: 16'h0005, phantom: 1'b0, data: 8'hA5};
        chk("t1_ins_valid", {31'd0, ins_valid}, 32'd1);
        chk("t1_ins_fifo", {31'd0, ins_fifo_id}, 32'd1);
        chk("t1_ins_addr", {29'd0, ins_addr}, 32'd3);
        chk("t1_ins_pkt", 32'(ins_pkt), 32'(exp_pkt));
        chk("t1_miss", {31'd0, miss}, 32'd0);
        ins_ack = 1'b1;
        tick();
        ins_ack = 1'b0;
        chk("t1_count0", {28'd0, map_count}, 32'd0);
        chk("t1_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        chk("t1_ins_done", {31'd0, ins_valid}, 32'd0);

        // Fill the map
        for (int i = 0; i < 8; i++) begin
            record(16'h0010 + 16'(i), 1'(i % 2), 3'(i));
        end
        chk("t2_count8", {28'd0, map_count}, 32'd8);
        chk("t2_not_ready", {31'd0, rec_ready}, 32'd0);
        record(16'h0100, 1'b0, 3'd1);
        chk("t2_drop_pulse", {31'd0, rec_drop}, 32'd1);
        chk("t2_count_stay", {28'd0, map_count}, 32'd8);
        record(16'h0012, 1'b0, 3'd6);
        chk("t2_drop_clear", {31'd0, rec_drop}, 32'd0);
        chk("t2_overwrite_count", {28'd0, map_count}, 32'd8);

        // Lookup of the overwritten entry, held without ack
        lookup(16'h0012, 8'h3C);
        for (int k = 0; k < 4; k++) begin
            chk("t4_hold_valid", {31'd0, ins_valid}, 32'd1);
            chk("t4_hold_addr", {29'd0, ins_addr}, 32'd6);
            chk("t4_hold_fifo", {31'd0, ins_fifo_id}, 32'd0);
            chk("t4_hold_count", {28'd0, map_count}, 32'd8);
            tick();
        end

        // Ack and new report in the same cycle while full
        ins_ack     = 1'b1;
        rec_valid   = 1'b1;
        rec_id      = 16'h0200;
        rec_fifo_id = 1'b1;
        rec_addr    = 3'd2;
        tick();
        ins_ack   = 1'b0;
        rec_valid = 1'b0;
        chk("t5_drop", {31'd0, rec_drop}, 32'd1);
        chk("t5_count7", {28'd0, map_count}, 32'd7);
        chk("t5_idle", {31'd0, ins_valid}, 32'd0);
        record(16'h0201, 1'b1, 3'd5);
        chk("t5_count8", {28'd0, map_count}, 32'd8);
        chk("t5_no_drop", {31'd0, rec_drop}, 32'd0);

        // Unknown id misses for exactly one cycle
        lookup(16'h0ABC, 8'h00);
        chk("t3_miss", {31'd0, miss}, 32'd1);
        chk("t3_no_ins", {31'd0, ins_valid}, 32'd0);
        chk("t3_idle", {31'd0, pkt_ready}, 32'd1);
        tick();
        chk("t3_miss_end", {31'd0, miss}, 32'd0);

        // Overwrite of the entry in INSERT does not disturb outputs
        lookup(16'h0013, 8'h77);
        chk("t6_ins_valid", {31'd0, ins_valid}, 32'd1);
        chk("t6_ins_addr", {29'd0, ins_addr}, 32'd3);
        record(16'h0013, 1'b0, 3'd7);
        chk("t6_latched_addr", {29'd0, ins_addr}, 32'd3);
        chk("t6_latched_fifo", {31'd0, ins_fifo_id}, 32'd1);

        // Asynchronous reset mid-INSERT
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_ins", {31'd0, ins_valid}, 32'd0);
        chk("t6_async_count", {28'd0, map_count}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        lookup(16'h0013, 8'h01);
        chk("t6_after_rst_miss", {31'd0, miss}, 32'd1);
        chk("t6_after_rst_noins", {31'd0, ins_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mp5_phantom_map.md
Name: mp5_phantom_map

Overview:
- Address-map responder for the MP5 stage phantom-reservation interface.
- It records each phantom reservation (packet id -> FIFO id and slot address) that a stage reports on push.
- When the matching real packet later arrives, it looks up the reservation and drives the stage's insert port to fill the reserved slot, then frees the map entry.
- One instance sits beside each mp5_stage.

Parameters:
- NUM_PIPELINES, 2, number of per-stage FIFOs; power of two.
- FIFO_SIZE, 8, depth of each stage FIFO; sets the address width.
- MAP_DEPTH, 8, number of outstanding reservations the map can hold.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- rec_valid  in  1  phantom reservation report from the stage (push of a phantom packet).
- rec_id  in  16  phantom packet id.
- rec_fifo_id  in  $clog2(NUM_PIPELINES)  FIFO holding the reservation.
- rec_addr  in  $clog2(FIFO_SIZE)  reserved slot address.
- rec_ready  out  1  map can accept a new id.
- rec_drop  out  1  one-cycle pulse: report lost because the map was full.
- pkt_valid  in  1  real (non-phantom) packet to place.
- pkt_in  in  Packet  the real packet.
- pkt_ready  out  1  lookup engine idle.
- ins_valid  out  1  insert request to the stage.
- ins_fifo_id  out  $clog2(NUM_PIPELINES)  target FIFO.
- ins_addr  out  $clog2(FIFO_SIZE)  target slot.
- ins_pkt  out  Packet  packet to write.
- ins_ack  in  1  stage performed the insert this cycle (insert is not blocked by push).
- miss  out  1  one-cycle pulse: no reservation found for pkt_in.id.
- map_count  out  $clog2(MAP_DEPTH+1)  number of valid entries.

Behaviour:
- Reset (rst low, asynchronous):
  - All entry valid bits cleared; FSM returns to IDLE.
  - ins_valid, miss, rec_drop are 0; map_count is 0; ins_fifo_id, ins_addr, ins_pkt are 0.
  - Any packet in flight is discarded.
- Table: MAP_DEPTH entries of {valid, id[15:0], fifo_id, addr}.
- Record, on a clock edge with rec_valid=1:
  - If rec_id matches a valid entry, that entry's fifo_id/addr are overwritten; no new allocation, accepted even when full.
  - Else, if map_count < MAP_DEPTH, the lowest-index free entry is allocated.
  - Else the report is dropped and rec_drop pulses in the next cycle.
  - rec_ready = (map_count < MAP_DEPTH), combinational from registered state.
  - The new entry is visible to lookups from the next cycle.
- Lookup FSM:
  - IDLE: pkt_ready=1. If pkt_valid, latch pkt_in, go to LOOKUP.
  - LOOKUP (1 cycle): compare the latched id against all valid entries using the table state of this cycle. A record of the same id in this same cycle is not seen.
    - On hit: register fifo_id, addr and hit index; go to INSERT.
    - On miss: pulse miss in the next cycle; go to IDLE.
  - INSERT: ins_valid=1 with stable ins_fifo_id, ins_addr, ins_pkt. Hold until ins_ack=1. On the ack edge, clear the hit entry's valid bit and go to IDLE.
- Latency: pkt accepted at edge E0; ins_valid asserts after E1 at the earliest; the entry is freed at the ack edge.
- ins_ack while not in INSERT: ignored.
- Record and free in the same cycle:
  - Both take effect and map_count nets out (+1-1 = 0).
  - A record may allocate the entry being freed only from the next cycle.
  - A record overwriting the entry currently in INSERT updates the table, but the outputs keep their latched values.
- map_count saturates logically at MAP_DEPTH; it never wraps.
- Multiple hits are impossible: duplicate ids overwrite instead of allocating. A multi-hit picks the lowest index.

Decomposition:
- Shared package mp5_pkg:
  - NUM_PIPELINES, NUM_STAGES, FIFO_SIZE.
  - Packet, FIFO_Entry, Entry typedefs.
  - New Map_Entry typedef {valid, id, fifo_id, addr}.
  - FSM state enum {IDLE, LOOKUP, INSERT}.
- One sub-module: mp5_map_match, a combinational priority match over MAP_DEPTH entries returning hit and index. The same block serves the record path (duplicate check) and the lookup path.

Test Plan:
- Reset, then record id=0x0005, fifo 1, addr 3. Next cycle pkt_in.id=0x0005 with pkt_valid -> ins_valid high 2 cycles after acceptance with fifo_id=1, addr=3; ins_ack=1 -> map_count 1->0, pkt_ready=1 next cycle.
- Record 8 distinct ids -> map_count=8, rec_ready=0; 9th record id=0x0100 -> rec_drop pulse, count stays 8; re-record id of entry 2 with addr 6 -> accepted, count 8, lookup returns addr 6.
- pkt_valid with id=0x0ABC never recorded -> miss pulses exactly one cycle, ins_valid stays 0, FSM back to IDLE.
- Hit with ins_ack held 0 for 4 cycles -> ins_valid and outputs stable for 4 cycles; entry freed only on the ack edge.
- Map full, in INSERT, ins_ack and a new rec_valid in the same cycle -> new record dropped (rec_ready was 0), count 8->7; a record the following cycle is accepted, count back to 8.
- Assert rst low mid-INSERT -> ins_valid drops immediately (asynchronous), map_count=0, a subsequent lookup of the old id misses.
